wavelet_lift_queue: RTL

Parametrised successor to the row wavelet queue. Accepts one line of pixels as even/odd sample pairs and performs a reversible CDF 5/3 integer lifting step (predict + update) with symmetric boundary extension. Emits low-band and high-band coefficient pairs with Mallat-layout buffer addresses. Sits between the line buffer and the coefficient RAM in the image coder's row-transform stage.

---
 rtl/wavelet_pkg.sv | 25 ++
 rtl/wavelet_lift_dp.sv | 30 +++
 rtl/wavelet_lift_queue.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/wavelet_pkg.sv
// Shared state encoding, lifting constants and width helpers for the
// wavelet row-transform queue.
package wavelet_pkg;

  typedef enum logic [1:0] {
    S_FIRST = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_e;

  localparam int unsigned LIFT_ROUND    = 2;
  localparam int unsigned PREDICT_SHIFT = 1;
  localparam int unsigned UPDATE_SHIFT  = 2;

  // Coefficient width that holds an unclamped 5/3 lifting result.
  function automatic int unsigned out_width(input int unsigned data_w);
    return data_w + 2;
  endfunction

  // Counter width for a pair index, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned pairs);
    return (pairs > 1) ? $clog2(pairs) : 1;
  endfunction

endpackage

// File: rtl/wavelet_lift_dp.sv
// Combinational CDF 5/3 predict/update step; left_edge_i mirrors d[-1] := d[0].
module wavelet_lift_dp
  import wavelet_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned INT_W  = DATA_W + 3
) (
  input  logic signed [DATA_W-1:0] x_even_i,
  input  logic signed [DATA_W-1:0] x_odd_i,
  input  logic signed [DATA_W-1:0] x_next_i,
  input  logic signed [INT_W-1:0]  d_prev_i,
  input  logic                     left_edge_i,
  output logic signed [INT_W-1:0]  d_o,
  output logic signed [INT_W-1:0]  s_o
);

  logic signed [INT_W-1:0] pair_sum;
  logic signed [INT_W-1:0] d_left;
  logic signed [INT_W-1:0] upd_sum;

  // Floors are arithmetic right shifts on full-precision sums.
  always_comb begin
    pair_sum = INT_W'(x_even_i) + INT_W'(x_next_i);
    d_o      = INT_W'(x_odd_i) - (pair_sum >>> PREDICT_SHIFT);
    d_left   = left_edge_i ? d_o : d_prev_i;
    upd_sum  = d_left + d_o + $signed(INT_W'(LIFT_ROUND));
    s_o      = INT_W'(x_even_i) + (upd_sum >>> UPDATE_SHIFT);
  end

endmodule

// File: rtl/wavelet_lift_queue.sv
// Row wavelet queue: CDF 5/3 lifting over one line of even/odd pairs with
// Mallat addresses. Define WAVELET_CLAMP_EN to saturate outputs and add sat_flag.
module wavelet_lift_queue
  import wavelet_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned OUT_W       = out_width(DATA_W),
  parameter int unsigned LINE_LEN    = 16,
  parameter int unsigned LINE_ADDR_W = 8,
  parameter int unsigned ADDR_W      = 12
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [DATA_W-1:0]   data_in_even,
  input  logic signed [DATA_W-1:0]   data_in_odd,
  input  logic [LINE_ADDR_W-1:0]     line_address,
  output logic                       output_valid,
  output logic signed [OUT_W-1:0]    data_out_low,
  output logic signed [OUT_W-1:0]    data_out_high,
  output logic [ADDR_W-1:0]          low_address,
  output logic [ADDR_W-1:0]          high_address,
  output logic                       line_done
`ifdef WAVELET_CLAMP_EN
  ,
  output logic                       sat_flag
`endif
);

  localparam int unsigned IW        = DATA_W + 3;
  localparam int unsigned HALF      = LINE_LEN / 2;
  localparam int unsigned LAST_PAIR = HALF - 1;
  localparam int unsigned CNT_W     = cnt_width(HALF);

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [DATA_W-1:0] x_even_q, x_even_d;
  logic signed [DATA_W-1:0] x_odd_q, x_odd_d;
  logic signed [IW-1:0]     d_prev_q, d_prev_d;
  logic [LINE_ADDR_W-1:0]   line_q, line_d;
  logic                     ready_q, ready_d;
  logic                     valid_q, valid_d;
  logic                     done_q, done_d;
  logic signed [OUT_W-1:0]  low_q, low_d;
  logic signed [OUT_W-1:0]  high_q, high_d;
  logic [ADDR_W-1:0]        low_addr_q, low_addr_d;
  logic [ADDR_W-1:0]        high_addr_q, high_addr_d;
  logic                     sat_q, sat_d;

  logic signed [DATA_W-1:0] x_next_c;
  logic                     left_edge_c;
  logic signed [IW-1:0]     dp_d, dp_s;
  logic signed [IW-1:0]     s_clip, d_clip;
  logic                     sat_c;
  logic [31:0]              addr_c;
  logic                     accept_c;

  // The flush step substitutes the mirrored sample x[LINE_LEN] := x[LINE_LEN-2].
  assign x_next_c    = (state_q == S_FLUSH) ? x_even_q : data_in_even;
  assign left_edge_c = (cnt_q == '0);
  assign accept_c    = in_valid && ready_q;

  wavelet_lift_dp #(
    .DATA_W (DATA_W),
    .INT_W  (IW)
  ) u_dp (
    .x_even_i    (x_even_q),
    .x_odd_i     (x_odd_q),
    .x_next_i    (x_next_c),
    .d_prev_i    (d_prev_q),
    .left_edge_i (left_edge_c),
    .d_o         (dp_d),
    .s_o         (dp_s)
  );

`ifdef WAVELET_CLAMP_EN
  localparam logic signed [IW-1:0] SAT_MAX = $signed((IW'(1) << (DATA_W - 1)) - IW'(1));
  localparam logic signed [IW-1:0] SAT_MIN = ~SAT_MAX;

  // Saturation only shapes the outputs; d_prev keeps the raw value.
  always_comb begin
    s_clip = dp_s;
    d_clip = dp_d;
    sat_c  = 1'b0;
    if (dp_s > SAT_MAX) begin
      s_clip = SAT_MAX;
      sat_c  = 1'b1;
    end else if (dp_s < SAT_MIN) begin
      s_clip = SAT_MIN;
      sat_c  = 1'b1;
    end
    if (dp_d > SAT_MAX) begin
      d_clip = SAT_MAX;
      sat_c  = 1'b1;
    end else if (dp_d < SAT_MIN) begin
      d_clip = SAT_MIN;
      sat_c  = 1'b1;
    end
  end
`else
  always_comb begin
    s_clip = dp_s;
    d_clip = dp_d;
    sat_c  = 1'b0;
  end
`endif

  assign addr_c = 32'(line_q) * 32'(LINE_LEN) + 32'(cnt_q);

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    x_even_d    = x_even_q;
    x_odd_d     = x_odd_q;
    d_prev_d    = d_prev_q;
    line_d      = line_q;
    valid_d     = 1'b0;
    done_d      = 1'b0;
    low_d       = low_q;
    high_d      = high_q;
    low_addr_d  = low_addr_q;
    high_addr_d = high_addr_q;
    sat_d       = 1'b0;

    unique case (state_q)
      S_FIRST: begin
        if (accept_c) begin
          x_even_d = data_in_even;
          x_odd_d  = data_in_odd;
          line_d   = line_address;
          cnt_d    = '0;
          state_d  = (LAST_PAIR == 0) ? S_FLUSH : S_RUN;
        end
      end
      S_RUN: begin
        if (accept_c) begin
          valid_d  = 1'b1;
          x_even_d = data_in_even;
          x_odd_d  = data_in_odd;
          d_prev_d = dp_d;
          cnt_d    = cnt_q + CNT_W'(1);
          if (32'(cnt_q) + 32'd1 == LAST_PAIR) begin
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        valid_d = 1'b1;
        done_d  = 1'b1;
        state_d = S_FIRST;
      end
      default: state_d = S_FIRST;
    endcase

    if (valid_d) begin
      low_d       = OUT_W'(s_clip);
      high_d      = OUT_W'(d_clip);
      low_addr_d  = ADDR_W'(addr_c);
      high_addr_d = ADDR_W'(addr_c + 32'(HALF));
      sat_d       = sat_c;
    end

    ready_d = (state_d != S_FLUSH);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_FIRST;
      cnt_q       <= '0;
      x_even_q    <= '0;
      x_odd_q     <= '0;
      d_prev_q    <= '0;
      line_q      <= '0;
      ready_q     <= 1'b1;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      low_q       <= '0;
      high_q      <= '0;
      low_addr_q  <= '0;
      high_addr_q <= '0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_even_q    <= x_even_d;
      x_odd_q     <= x_odd_d;
      d_prev_q    <= d_prev_d;
      line_q      <= line_d;
      ready_q     <= ready_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      low_q       <= low_d;
      high_q      <= high_d;
      low_addr_q  <= low_addr_d;
      high_addr_q <= high_addr_d;
      sat_q       <= sat_d;
    end
  end

  assign in_ready      = ready_q;
  assign output_valid  = valid_q;
  assign line_done     = done_q;
  assign data_out_low  = low_q;
  assign data_out_high = high_q;
  assign low_address   = low_addr_q;
  assign high_address  = high_addr_q;
`ifdef WAVELET_CLAMP_EN
  assign sat_flag      = sat_q;
`endif

endmodule
